// File: rtl/spi_rom_line_fetcher.sv
// SPI flash line fetcher: READ burst into a back buffer, swapped to a front buffer for the pixel shifter.
// FAST_READ_EN selects FAST READ (0Bh) with 8 dummy bits instead of CMD_READ.
module spi_rom_line_fetcher #(
  parameter int         ADDR_BITS = 24,
  parameter int         DATA_BITS = 128,
  parameter logic [7:0] CMD_READ  = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  input  logic                 pix_shift,
  output logic                 pix_bit,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

`ifdef FAST_READ_EN
  localparam logic [7:0] CMD_BYTE   = 8'h0B;
  localparam int         DUMMY_BITS = 8;
`else
  localparam logic [7:0] CMD_BYTE   = CMD_READ;
  localparam int         DUMMY_BITS = 0;
`endif

  localparam int N     = 8 + ADDR_BITS + DUMMY_BITS + DATA_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int TX_W  = 8 + ADDR_BITS;

  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(8 + ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(8 + ADDR_BITS + DUMMY_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cs;
  logic                   r_sclk;
  logic                   r_mosi;
  logic [TX_W-1:0]        r_tx;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]   r_front;
  logic [DATA_BITS-1:0]   r_back;

  logic                   w_accept;
  logic                   w_abort;
  logic                   w_bit_end;
  logic                   w_final;
  logic [DATA_BITS-1:0]   w_back_shifted;

  assign w_accept       = start && !r_busy;
  assign w_abort        = abort && r_busy;
  // A bit completes on the edge that drops sclk; that is also the MISO sample point.
  assign w_bit_end      = r_busy && r_sclk;
  assign w_final        = w_bit_end && (r_state == S_DATA) && (r_bit_cnt == LAST_DATA) && !abort;
  assign w_back_shifted = {r_back[DATA_BITS-2:0], spi_miso};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_CMD;
        S_CMD:   if (w_bit_end && r_bit_cnt == LAST_CMD) w_state_nxt = S_ADDR;
`ifdef FAST_READ_EN
        S_ADDR:  if (w_bit_end && r_bit_cnt == LAST_ADDR) w_state_nxt = S_DUMMY;
`else
        S_ADDR:  if (w_bit_end && r_bit_cnt == LAST_ADDR) w_state_nxt = S_DATA;
`endif
        S_DUMMY: if (w_bit_end && r_bit_cnt == LAST_DUMMY) w_state_nxt = S_DATA;
        S_DATA:  if (w_bit_end && r_bit_cnt == LAST_DATA) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_tx      <= '0;
      r_bit_cnt <= '0;
      r_back    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_busy <= 1'b0;
        r_cs   <= 1'b0;
        r_sclk <= 1'b0;
        r_mosi <= 1'b0;
        r_back <= '0;
      end else if (w_accept) begin
        r_busy    <= 1'b1;
        r_cs      <= 1'b1;
        r_sclk    <= 1'b0;
        r_mosi    <= CMD_BYTE[7];
        r_tx      <= {CMD_BYTE[6:0], addr, 1'b0};
        r_bit_cnt <= '0;
        r_back    <= '0;
      end else if (r_busy) begin
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else begin
          // Once command and address drain, zeros shift out for dummy and data bits.
          r_sclk    <= 1'b0;
          r_mosi    <= r_tx[TX_W-1];
          r_tx      <= {r_tx[TX_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (r_state == S_DATA) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_busy <= 1'b0;
              r_cs   <= 1'b0;
              r_mosi <= 1'b0;
              r_done <= 1'b1;
              r_back <= '0;
            end else begin
              r_back <= w_back_shifted;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_front <= '0;
    end else if (w_final) begin
      r_front <= w_back_shifted;
    end else if (pix_shift) begin
      r_front <= {r_front[DATA_BITS-2:0], 1'b0};
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_cs   = r_cs;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign pix_bit  = r_front[DATA_BITS-1];

endmodule
